// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the calc_seq calculator core.
//   Command codes (keypad nibble), status codes, FSM state and operator enums,
//   and a pow10 helper for the decimal range limit.
//   Divide support is selected in the design files by the CALC_DIV_EN macro.
package calc_pkg;

   localparam logic [3:0] CMD_ADD  = 4'hA;
   localparam logic [3:0] CMD_SUB  = 4'hB;
   localparam logic [3:0] CMD_MUL  = 4'hC;
   localparam logic [3:0] CMD_DIV  = 4'hD;
   localparam logic [3:0] CMD_EQ   = 4'hE;
   localparam logic [3:0] CMD_BKSP = 4'hF;

   localparam logic [1:0] ST_ERROR = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_READY = 2'b10;

   typedef enum logic [2:0] {
      S_ENTER_A,
      S_ENTER_B,
      S_EXEC,
      S_SCAN,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_DIV
   } op_t;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/calc_seq_alu.sv
// calc_seq_alu -- iterative multiply (and optional divide) engine.
//   Multiply: shift-add, WIDTH cycles, full 2*WIDTH product on prod_o.
//   Divide (only when CALC_DIV_EN is defined): restoring, WIDTH cycles,
//   quotient on quot_o, remainder discarded.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   start_i       one-cycle pulse, samples a_i/b_i (and div_i)
//   div_i         1 = divide a_i/b_i, 0 = multiply (CALC_DIV_EN only)
//   a_i, b_i      operands (multiplier/multiplicand, dividend/divisor)
//   done_o        one-cycle pulse when the result is valid
//   prod_o        product
//   quot_o        quotient (CALC_DIV_EN only)
module calc_seq_alu #(
   parameter int unsigned WIDTH = 27
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start_i,
`ifdef CALC_DIV_EN
   input  logic                 div_i,
`endif
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   prod_o
`ifdef CALC_DIV_EN
   ,
   output logic [WIDTH-1:0]     quot_o
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
`ifdef CALC_DIV_EN
   logic               div_q;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_sub;
   logic [2*WIDTH-1:0] div_step;
`endif

   // prod_q holds {hi, lo}: lo starts as multiplier/dividend; mcand_q holds
   // the multiplicand/divisor. Multiply shifts right, divide shifts left.
   always_comb begin
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      mul_step = {mul_sum, prod_q[WIDTH-1:1]};
`ifdef CALC_DIV_EN
      rem_sh  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      rem_sub = rem_sh[WIDTH-1:0] - mcand_q;
      if (rem_sh >= {1'b0, mcand_q}) div_step = {rem_sub, prod_q[WIDTH-2:0], 1'b1};
      else                           div_step = {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prod_q  <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef CALC_DIV_EN
         div_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            prod_q  <= {{WIDTH{1'b0}}, a_i};
            mcand_q <= b_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`ifdef CALC_DIV_EN
            div_q   <= div_i;
`endif
         end else if (busy_q) begin
`ifdef CALC_DIV_EN
            prod_q <= div_q ? div_step : mul_step;
`else
            prod_q <= mul_step;
`endif
            if (cnt_q == CW'(WIDTH - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign prod_o = prod_q;
`ifdef CALC_DIV_EN
   assign quot_o = prod_q[WIDTH-1:0];
`endif

endmodule

// File: rtl/calc_seq.sv
// calc_seq -- decimal calculator core: NDIG-digit operand entry, add/sub/mul
//   (divide when CALC_DIV_EN is defined) on a binary accumulator, and a
//   per-digit BCD scan-out of the displayed value after every accepted command.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   cmd           0-9 digit, A add, B sub, C mul, D div, E equals, F backspace
//   cmd_valid     command qualifier, taken only while status is READY
//   status        00 ERROR, 01 BUSY, 10 READY
//   data, pos     scanned BCD digit and its index (0 = least significant)
//   data_valid    data/pos valid this cycle
//   neg           displayed value is negative (subtract result only)
// Without CALC_DIV_EN there is no divider and cmd D is an invalid operator.
module calc_seq
   import calc_pkg::*;
#(
   parameter int unsigned NDIG  = 8,
   parameter int unsigned WIDTH = 27,
   parameter int unsigned POSW  = $clog2(NDIG)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [3:0]      cmd,
   input  logic            cmd_valid,
   output logic [1:0]      status,
   output logic [3:0]      data,
   output logic [POSW-1:0] pos,
   output logic            data_valid,
   output logic            neg
);

   localparam longint unsigned MAXV = pow10(NDIG) - 64'd1;
   localparam logic [WIDTH+3:0]   MAXV_X = (WIDTH+4)'(MAXV);
   localparam logic [WIDTH:0]     MAXV_S = (WIDTH+1)'(MAXV);
   localparam logic [2*WIDTH-1:0] MAXV_P = (2*WIDTH)'(MAXV);

   state_t           state_q, ret_q;
   op_t              op_q;
   logic [WIDTH-1:0] a_q, b_q, v_q, shadow_q;
   logic [POSW:0]    scnt_q;
   logic [1:0]       status_q;
   logic [3:0]       data_q;
   logic [POSW-1:0]  pos_q;
   logic             dv_q, neg_q, start_q;

   logic [WIDTH+3:0]   app;
   logic [WIDTH-1:0]   v_d;
   logic [WIDTH-1:0]   sh_div10;
   logic [3:0]         sh_dig;
   logic               cmd_is_digit, cmd_is_op;
   op_t                cmd_op;
   logic [WIDTH:0]     sum;
   logic               ex_fin, ex_err, ex_neg;
   logic [WIDTH-1:0]   ex_res;
   logic               alu_done;
   logic [2*WIDTH-1:0] alu_prod;
`ifdef CALC_DIV_EN
   logic [WIDTH-1:0]   alu_quot;
`endif

   calc_seq_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .clock   (clock),
      .reset   (reset),
      .start_i (start_q),
`ifdef CALC_DIV_EN
      .div_i   (op_q == OP_DIV),
`endif
      .a_i     (a_q),
      .b_i     (b_q),
      .done_o  (alu_done),
      .prod_o  (alu_prod)
`ifdef CALC_DIV_EN
      ,
      .quot_o  (alu_quot)
`endif
   );

   // Entry value update and command decode.
   always_comb begin
      cmd_is_digit = (cmd < 4'd10);
      app = ({4'b0, v_q} * (WIDTH+4)'(10)) + (WIDTH+4)'(cmd);
      v_d = v_q;
      if (cmd == CMD_BKSP)     v_d = v_q / WIDTH'(10);
      else if (app <= MAXV_X)  v_d = app[WIDTH-1:0];

      cmd_op    = OP_ADD;
      cmd_is_op = 1'b0;
      case (cmd)
         CMD_ADD: begin cmd_op = OP_ADD; cmd_is_op = 1'b1; end
         CMD_SUB: begin cmd_op = OP_SUB; cmd_is_op = 1'b1; end
         CMD_MUL: begin cmd_op = OP_MUL; cmd_is_op = 1'b1; end
         CMD_DIV: begin
            cmd_op = OP_DIV;
`ifdef CALC_DIV_EN
            cmd_is_op = 1'b1;
`endif
         end
         default: ;
      endcase

      sh_div10 = shadow_q / WIDTH'(10);
      sh_dig   = 4'(shadow_q - sh_div10 * WIDTH'(10));
   end

   // Execution result: ex_fin marks the cycle the result is final.
   always_comb begin
      sum    = {1'b0, a_q} + {1'b0, b_q};
      ex_fin = 1'b0;
      ex_err = 1'b0;
      ex_neg = 1'b0;
      ex_res = '0;
      unique case (op_q)
         OP_ADD: begin
            ex_fin = 1'b1;
            ex_err = (sum > MAXV_S);
            ex_res = sum[WIDTH-1:0];
         end
         OP_SUB: begin
            ex_fin = 1'b1;
            if (a_q >= b_q) ex_res = a_q - b_q;
            else begin
               ex_res = b_q - a_q;
               ex_neg = 1'b1;
            end
         end
         OP_MUL: begin
            ex_fin = alu_done;
            ex_err = (alu_prod > MAXV_P);
            ex_res = alu_prod[WIDTH-1:0];
         end
         OP_DIV: begin
`ifdef CALC_DIV_EN
            if (b_q == '0) begin
               ex_fin = 1'b1;
               ex_err = 1'b1;
            end else begin
               ex_fin = alu_done;
               ex_res = alu_quot;
            end
`else
            ex_fin = 1'b1;
            ex_err = 1'b1;
`endif
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_ENTER_A;
         ret_q    <= S_ENTER_A;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         v_q      <= '0;
         shadow_q <= '0;
         scnt_q   <= '0;
         status_q <= ST_BUSY;
         data_q   <= '0;
         pos_q    <= '0;
         dv_q     <= 1'b0;
         neg_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         unique case (state_q)
            S_ENTER_A, S_ENTER_B: begin
               if (status_q != ST_READY) begin
                  // Entry state while BUSY only happens straight out of reset:
                  // show the initial zero before going READY.
                  shadow_q <= v_q;
                  scnt_q   <= '0;
                  ret_q    <= state_q;
                  state_q  <= S_SCAN;
               end else if (cmd_valid) begin
                  status_q <= ST_BUSY;
                  neg_q    <= 1'b0;
                  if (cmd_is_digit || cmd == CMD_BKSP) begin
                     v_q      <= v_d;
                     shadow_q <= v_d;
                     scnt_q   <= '0;
                     ret_q    <= state_q;
                     state_q  <= S_SCAN;
                  end else if (cmd == CMD_EQ) begin
                     if (state_q == S_ENTER_A) begin
                        shadow_q <= v_q;
                        scnt_q   <= '0;
                        ret_q    <= S_ENTER_A;
                        state_q  <= S_SCAN;
                     end else begin
                        b_q     <= v_q;
                        start_q <= (op_q == OP_MUL) || (op_q == OP_DIV);
                        state_q <= S_EXEC;
                     end
                  end else if (cmd_is_op && state_q == S_ENTER_A) begin
                     a_q      <= v_q;
                     op_q     <= cmd_op;
                     v_q      <= '0;
                     shadow_q <= '0;
                     scnt_q   <= '0;
                     ret_q    <= S_ENTER_B;
                     state_q  <= S_SCAN;
                  end else begin
                     status_q <= ST_ERROR;
                     state_q  <= S_ERR;
                  end
               end
            end
            S_EXEC: begin
               if (ex_fin) begin
                  if (ex_err) begin
                     status_q <= ST_ERROR;
                     state_q  <= S_ERR;
                  end else begin
                     v_q      <= ex_res;
                     shadow_q <= ex_res;
                     neg_q    <= ex_neg;
                     scnt_q   <= '0;
                     ret_q    <= S_ENTER_A;
                     state_q  <= S_SCAN;
                  end
               end
            end
            S_SCAN: begin
               if (scnt_q == (POSW+1)'(NDIG)) begin
                  dv_q     <= 1'b0;
                  data_q   <= '0;
                  pos_q    <= '0;
                  status_q <= ST_READY;
                  state_q  <= ret_q;
               end else begin
                  data_q   <= sh_dig;
                  pos_q    <= scnt_q[POSW-1:0];
                  dv_q     <= 1'b1;
                  shadow_q <= sh_div10;
                  scnt_q   <= scnt_q + 1'b1;
               end
            end
            S_ERR: begin
               status_q <= ST_ERROR;
            end
         endcase
      end
   end

   assign status     = status_q;
   assign data       = data_q;
   assign pos        = pos_q;
   assign data_valid = dv_q;
   assign neg        = neg_q;

endmodule
